cdb_broadcaster: RTL

Transmit end of the common data bus (CDB) that the reservation stations and register status snoop. Collects completed results (ROB tag plus 32-bit value) from the functional units (ALU, branch, load/store), buffers them in a small in-order queue, and drives the two CDB channels. Each broadcast is a one-cycle strobe pulse carrying the tag and data, because consumers capture on the strobe's rising edge.

---
 rtl/cdb_pkg.sv | 18 +
 rtl/cdb_rr_arbiter.sv | 51 +++++
 rtl/cdb_broadcaster.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared types and constants for the CDB transmit path.
//   ROB_W        : ROB tag width
//   INVALID_ROB  : tag driven when a channel is idle ("no producer")
//   cdb_entry_t  : one queued result (tag + 32-bit value)
//   is_valid_tag : true for real ROB tags (0..15)
package cdb_pkg;
  localparam int ROB_W = 6;
  localparam logic [ROB_W-1:0] INVALID_ROB = 6'b010000;

  typedef struct packed {
    logic [ROB_W-1:0] rob;
    logic [31:0]      data;
  } cdb_entry_t;

  function automatic logic is_valid_tag(input logic [ROB_W-1:0] tag);
    return tag < ROB_W'(16);
  endfunction
endpackage

// File: rtl/cdb_rr_arbiter.sv
// cdb_rr_arbiter: rotating-priority arbiter issuing up to two one-hot grants
// per cycle.
//   clock, reset : clock, synchronous active-low reset (clears pointer)
//   req          : per-source request
//   max_gnt      : grants allowed this cycle (0..2)
//   gnt0         : first (older) grant, one-hot or zero
//   gnt1         : second (younger) grant, one-hot or zero
// The pointer moves one past the last granted source and holds when idle.
module cdb_rr_arbiter #(
  parameter int NUM_SRC = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         max_gnt,
  output logic [NUM_SRC-1:0] gnt0,
  output logic [NUM_SRC-1:0] gnt1
);
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    int n;
    int idx;
    n     = 0;
    idx   = 0;
    gnt0  = '0;
    gnt1  = '0;
    ptr_d = ptr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(ptr_q) + k) % NUM_SRC;
      if (req[idx]) begin
        if (n == 0 && max_gnt >= 2'd1) begin
          gnt0[idx] = 1'b1;
          n         = 1;
          ptr_d     = PW'((idx + 1) % NUM_SRC);
        end else if (n == 1 && max_gnt >= 2'd2) begin
          gnt1[idx] = 1'b1;
          n         = 2;
          ptr_d     = PW'((idx + 1) % NUM_SRC);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: collects FU results into an in-order queue and drives the
// two CDB channels with registered one-cycle strobes.
//   clock, reset         : clock, synchronous active-low reset
//   src_valid/rob/data   : per-source result offer (held until granted)
//   src_ready            : combinational grant (invalid tags granted, dropped)
//   CDBiscast/robNum/data: channel 1 (oldest entry)
//   CDBiscast2/...2      : channel 2 (next oldest, or oldest if ch1 busy)
//   q_count              : queue occupancy
// Build option: CDB_BACK_TO_BACK_EN lets both strobes assert every cycle;
// without it a channel that strobed last cycle must idle, guaranteeing a
// rising edge per result for edge-triggered consumers.
module cdb_broadcaster
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*ROB_W-1:0] src_rob,
  input  logic [NUM_SRC*32-1:0]    src_data,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic                     CDBiscast,
  output logic [ROB_W-1:0]         CDBrobNum,
  output logic [31:0]              CDBdata,
  output logic                     CDBiscast2,
  output logic [ROB_W-1:0]         CDBrobNum2,
  output logic [31:0]              CDBdata2,
  output logic [$clog2(DEPTH):0]   q_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cdb_entry_t       mem_q [DEPTH];
  cdb_entry_t       mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cast1_q, cast1_d, cast2_q, cast2_d;
  logic [ROB_W-1:0] rob1_q, rob1_d, rob2_q, rob2_d;
  logic [31:0]      data1_q, data1_d, data2_q, data2_d;

  logic [CW-1:0]      free_slots;
  logic [1:0]         max_gnt;
  logic [NUM_SRC-1:0] gnt0, gnt1;
  cdb_entry_t         in0, in1, head0, head1;
  logic               av1, av2;
  logic [1:0]         n_push, n_pop;
  logic [AW-1:0]      wp;

  // Grant budget uses start-of-cycle occupancy only; a same-cycle dequeue
  // does not create room.
  always_comb begin
    free_slots = CW'(DEPTH) - cnt_q;
    if (!reset)                       max_gnt = 2'd0;
    else if (free_slots >= CW'(2))    max_gnt = 2'd2;
    else                              max_gnt = free_slots[1:0];
  end

  cdb_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (src_valid),
    .max_gnt (max_gnt),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  assign src_ready = gnt0 | gnt1;

  // One-hot grant to entry mux.
  always_comb begin
    in0 = '0;
    in1 = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt0[i]) in0 = {src_rob[i*ROB_W +: ROB_W], src_data[i*32 +: 32]};
      if (gnt1[i]) in1 = {src_rob[i*ROB_W +: ROB_W], src_data[i*32 +: 32]};
    end
  end

  always_comb begin
`ifdef CDB_BACK_TO_BACK_EN
    av1 = 1'b1;
    av2 = 1'b1;
`else
    av1 = !cast1_q;
    av2 = !cast2_q;
`endif
  end

  always_comb begin
    mem_d  = mem_q;
    wp     = wr_ptr_q;
    n_push = 2'd0;
    // Granted-but-invalid tags are consumed here without taking a slot.
    if (|gnt0 && is_valid_tag(in0.rob)) begin
      mem_d[wp] = in0;
      wp        = wp + AW'(1);
      n_push    = n_push + 2'd1;
    end
    if (|gnt1 && is_valid_tag(in1.rob)) begin
      mem_d[wp] = in1;
      wp        = wp + AW'(1);
      n_push    = n_push + 2'd1;
    end
    wr_ptr_d = wp;

    head0   = mem_q[rd_ptr_q];
    head1   = mem_q[rd_ptr_q + AW'(1)];
    cast1_d = 1'b0;
    cast2_d = 1'b0;
    rob1_d  = INVALID_ROB;
    rob2_d  = INVALID_ROB;
    data1_d = data1_q;
    data2_d = data2_q;
    n_pop   = 2'd0;
    // Oldest entry takes the first free channel; ch2 only gets the second
    // entry when ch1 is also taking one.
    if (cnt_q != '0) begin
      if (av1) begin
        cast1_d = 1'b1;
        rob1_d  = head0.rob;
        data1_d = head0.data;
        n_pop   = 2'd1;
        if (av2 && cnt_q >= CW'(2)) begin
          cast2_d = 1'b1;
          rob2_d  = head1.rob;
          data2_d = head1.data;
          n_pop   = 2'd2;
        end
      end else if (av2) begin
        cast2_d = 1'b1;
        rob2_d  = head0.rob;
        data2_d = head0.data;
        n_pop   = 2'd1;
      end
    end
    rd_ptr_d = rd_ptr_q + AW'(n_pop);
    cnt_d    = cnt_q + CW'(n_push) - CW'(n_pop);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      cast1_q  <= 1'b0;
      cast2_q  <= 1'b0;
      rob1_q   <= INVALID_ROB;
      rob2_q   <= INVALID_ROB;
      data1_q  <= '0;
      data2_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      cast1_q  <= cast1_d;
      cast2_q  <= cast2_d;
      rob1_q   <= rob1_d;
      rob2_q   <= rob2_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clock) mem_q <= mem_d;

  assign CDBiscast  = cast1_q;
  assign CDBrobNum  = rob1_q;
  assign CDBdata    = data1_q;
  assign CDBiscast2 = cast2_q;
  assign CDBrobNum2 = rob2_q;
  assign CDBdata2   = data2_q;
  assign q_count    = cnt_q;
endmodule
